// File: rtl/ahb_lite_manager.sv
// Single-outstanding AHB-Lite manager that turns a valid/ready request into one SINGLE transfer
// and returns one response per request. Misaligned or oversize requests are rejected locally.
module ahb_lite_manager #(
    parameter int unsigned AhbAddrWidth = 32,
    parameter int unsigned AhbDataWidth = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_write_i,
    input  logic [AhbAddrWidth-1:0]     req_addr_i,
    input  logic [2:0]                  req_size_i,
    input  logic [AhbDataWidth-1:0]     req_wdata_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [AhbDataWidth-1:0]     rsp_rdata_o,
    output logic                        rsp_error_o,
    output logic [AhbAddrWidth-1:0]     haddr_o,
    output logic [2:0]                  hburst_o,
    output logic [3:0]                  hprot_o,
    output logic [2:0]                  hsize_o,
    output logic [1:0]                  htrans_o,
    output logic [AhbDataWidth-1:0]     hwdata_o,
    output logic [AhbDataWidth/8-1:0]   hwstrb_o,
    output logic                        hwrite_o,
    output logic                        hsel_o,
    input  logic [AhbDataWidth-1:0]     hrdata_i,
    input  logic                        hready_i,
    input  logic                        hresp_i
);

    localparam int unsigned StrbW = AhbDataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam logic [1:0]  HtransIdle   = 2'b00;
    localparam logic [1:0]  HtransNonseq = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RSP} state_t;

    state_t                  state;
    logic [AhbDataWidth-1:0] cap_wdata;
    logic [StrbW-1:0]        cap_strb;

    logic [31:0]             lane_bytes;
    logic [31:0]             lane_mask;
    logic [StrbW-1:0]        lane_strb;
    logic                    misaligned;
    logic                    oversize;

    assign hburst_o = 3'b000;
    assign hprot_o  = 4'b0011;

    // Byte-lane decode of the incoming request; only meaningful when the request is legal.
    assign lane_bytes = 32'd1 << req_size_i;
    assign lane_mask  = (32'd1 << lane_bytes) - 32'd1;
    assign lane_strb  = StrbW'(lane_mask << req_addr_i[OffW-1:0]);
    assign misaligned = (req_addr_i[OffW-1:0] & OffW'(lane_bytes - 32'd1)) != '0;
    assign oversize   = req_size_i > 3'(OffW);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b0;
            htrans_o    <= HtransIdle;
            hsel_o      <= 1'b0;
            hwrite_o    <= 1'b0;
            haddr_o     <= '0;
            hsize_o     <= '0;
            hwdata_o    <= '0;
            hwstrb_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
            cap_wdata   <= '0;
            cap_strb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    htrans_o    <= HtransIdle;
                    hsel_o      <= 1'b0;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        haddr_o     <= req_addr_i;
                        hsize_o     <= req_size_i;
                        hwrite_o    <= req_write_i;
                        cap_wdata   <= req_wdata_i;
                        cap_strb    <= lane_strb;
                        if (misaligned || oversize) begin
                            rsp_valid_o <= 1'b1;
                            rsp_error_o <= 1'b1;
                            rsp_rdata_o <= '0;
                            state       <= RSP;
                        end else begin
                            hsel_o   <= 1'b1;
                            htrans_o <= HtransNonseq;
                            state    <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (hready_i) begin
                        hsel_o   <= 1'b0;
                        htrans_o <= HtransIdle;
                        hwdata_o <= hwrite_o ? cap_wdata : '0;
                        hwstrb_o <= hwrite_o ? cap_strb : '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    // First ERROR cycle has hready_i=0 and is absorbed as a wait state.
                    if (hready_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_error_o <= hresp_i;
                        rsp_rdata_o <= (!hwrite_o && !hresp_i) ? hrdata_i : '0;
                        hwdata_o    <= '0;
                        hwstrb_o    <= '0;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Bench for ahb_lite_manager: directed plan cases plus randomized transfers against a
// cycle-count reference model of the manager and a scripted subordinate.
module tb_ahb_lite_manager;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_error;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] haddr;
    logic [2:0]    hburst, hsize;
    logic [3:0]    hprot;
    logic [1:0]    htrans;
    logic [DW-1:0] hwdata, hrdata;
    logic [SW-1:0] hwstrb;
    logic          hwrite, hsel, hready, hresp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ahb_lite_manager #(.AhbAddrWidth(AW), .AhbDataWidth(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error),
        .haddr_o(haddr), .hburst_o(hburst), .hprot_o(hprot), .hsize_o(hsize),
        .htrans_o(htrans), .hwdata_o(hwdata), .hwstrb_o(hwstrb), .hwrite_o(hwrite),
        .hsel_o(hsel), .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_reject(input logic [2:0] size, input logic [31:0] addr);
        int unsigned nbytes;
        nbytes = 1 << size;
        return (nbytes > SW) || ((addr % nbytes) != 0);
    endfunction

    function automatic logic [SW-1:0] model_strb(input logic [2:0] size, input logic [31:0] addr);
        logic [SW-1:0] s;
        int unsigned off, nbytes;
        off = addr % SW;
        nbytes = 1 << size;
        for (int i = 0; i < SW; i++) s[i] = (i >= off) && (i < off + nbytes);
        return s;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", 64'(req_ready), 64'd1);
    endtask

    // One transfer: aw/dw are address/data phase wait states, hold is rsp_ready stall cycles.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [63:0] wdata, input int aw, input int dw, input bit err,
                           input logic [63:0] rdata, input int hold);
        bit rej;
        int last;
        logic [63:0] exp_rdata;
        rej = model_reject(size, addr);
        last = rej ? 1 : aw + dw + 3;
        exp_rdata = (!wr && !err && !rej) ? rdata : 64'd0;
        wait_ready();
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_wdata = '0;
        for (int k = 1; k < last; k++) begin
            hready = 1'b1; hresp = 1'b0; hrdata = {$urandom, $urandom};
            if (k <= aw + 1) begin
                chk("addr_htrans", 64'(htrans), 64'd2);
                chk("addr_hsel", 64'(hsel), 64'd1);
                chk("addr_haddr", 64'(haddr), 64'(addr));
                chk("addr_hsize", 64'(hsize), 64'(size));
                chk("addr_hwrite", 64'(hwrite), 64'(wr));
                hready = (k == aw + 1);
            end else begin
                chk("data_htrans", 64'(htrans), 64'd0);
                chk("data_hsel", 64'(hsel), 64'd0);
                chk("data_hwstrb", 64'(hwstrb), wr ? 64'(model_strb(size, addr)) : 64'd0);
                if (wr) chk("data_hwdata", hwdata, wdata);
                hready = (k == last - 1);
                if (err && k >= last - 2) hresp = 1'b1;
                if (k == last - 1) hrdata = rdata;
            end
            chk("pend_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("pend_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        hready = 1'b1; hresp = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_error", 64'(rsp_error), 64'(rej || err));
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_req_ready", 64'(req_ready), 64'd0);
            chk("rsp_htrans", 64'(htrans), 64'd0);
            rsp_ready = (h == hold);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("rsp_dropped", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        bit wr, err;
        logic [2:0] size;
        logic [31:0] addr;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
        req_wdata = '0; rsp_ready = 1'b0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("rst_hsel", 64'(hsel), 64'd0);
        chk("rst_hwrite", 64'(hwrite), 64'd0);
        chk("rst_haddr", 64'(haddr), 64'd0);
        chk("rst_hsize", 64'(hsize), 64'd0);
        chk("rst_hwdata", hwdata, 64'd0);
        chk("rst_hwstrb", 64'(hwstrb), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);
        chk("rst_hburst", 64'(hburst), 64'd0);
        chk("rst_hprot", 64'(hprot), 64'h3);
        rst = 1'b0;

        run_txn(1'b0, 32'h10, 3'd2, 64'd0, 0, 0, 1'b0, 64'hDEADBEEF_01234567, 0);
        run_txn(1'b1, 32'h5, 3'd0, 64'h0000_AB00_0000_0000, 0, 0, 1'b0, 64'd0, 0);
        run_txn(1'b0, 32'h40, 3'd3, 64'd0, 2, 3, 1'b0, 64'h1122_3344_5566_7788, 0);
        run_txn(1'b1, 32'h8, 3'd2, 64'h0000_0000_CAFE_F00D, 0, 1, 1'b1, 64'd0, 0);
        run_txn(1'b0, 32'h2, 3'd2, 64'd0, 0, 0, 1'b0, 64'hFFFF, 0);
        run_txn(1'b0, 32'h0, 3'd4, 64'd0, 0, 0, 1'b0, 64'hFFFF, 0);
        run_txn(1'b0, 32'h20, 3'd1, 64'd0, 0, 0, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0, 5);

        // Reset while the data phase is stalled by the subordinate.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30; req_size = 3'd3;
        @(negedge clk);
        req_valid = 1'b0; hready = 1'b1;
        @(negedge clk);
        chk("rstmid_in_data", 64'(htrans), 64'd0);
        hready = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstmid_htrans", 64'(htrans), 64'd0);
        chk("rstmid_hsel", 64'(hsel), 64'd0);
        chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid_req_ready", 64'(req_ready), 64'd0);
        chk("rstmid_hburst", 64'(hburst), 64'd0);
        chk("rstmid_hprot", 64'(hprot), 64'h3);
        rst = 1'b0; hready = 1'b1;
        @(negedge clk);
        chk("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
        run_txn(1'b1, 32'h1C, 3'd2, 64'h89AB_CDEF_0000_0000, 1, 0, 1'b0, 64'd0, 1);

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 4) != 0 && size < 3'd4)
                addr = addr & ~((32'd1 << size) - 32'd1);
            err  = ($urandom_range(0, 3) == 0);
            run_txn(wr, addr, size, {$urandom, $urandom}, $urandom_range(0, 3),
                    err ? $urandom_range(1, 3) : $urandom_range(0, 3), err,
                    {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ahb_lite_manager.md
Name: ahb_lite_manager

Overview:
- Single-outstanding AHB-Lite manager that converts a simple valid/ready request/response handshake into AHB-Lite SINGLE transfers.
- Used by the I3C testbench and by SoC-level test harnesses to drive the I3C core's AHB-Lite CSR subordinate port. It can also be built in as a firmware-less register sequencer front end.
- Handles subordinate wait states, two-cycle ERROR responses, and local rejection of misaligned or oversize requests.

Parameters:
- AhbAddrWidth, 32, width of haddr_o and req_addr_i.
- AhbDataWidth, 64, width of hwdata_o, hrdata_i and the request/response data; must be 32 or 64.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; one clock; reset is synchronous and active-high
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when valid&ready
- req_write_i  input  1  1=write, 0=read
- req_addr_i  input  AhbAddrWidth  byte address
- req_size_i  input  3  AHB hsize encoding (0=byte, 1=half, 2=word, 3=dword)
- req_wdata_i  input  AhbDataWidth  write data, already placed on its bus byte lanes
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed when valid&ready
- rsp_rdata_o  output  AhbDataWidth  read data (full bus word; 0 for writes)
- rsp_error_o  output  1  1 = bus ERROR or local reject
- haddr_o  output  AhbAddrWidth  AHB address
- hburst_o  output  3  constant 3'b000 (SINGLE)
- hprot_o  output  4  constant 4'b0011 (non-cacheable, non-bufferable, privileged, data)
- hsize_o  output  3  transfer size
- htrans_o  output  2  IDLE=2'b00 or NONSEQ=2'b10 only
- hwdata_o  output  AhbDataWidth  write data
- hwstrb_o  output  AhbDataWidth/8  write strobes
- hwrite_o  output  1  write indicator
- hsel_o  output  1  subordinate select
- hrdata_i  input  AhbDataWidth  read data
- hready_i  input  1  subordinate hreadyout
- hresp_i  input  1  subordinate error response

Behaviour:
- FSM states: IDLE, ADDR, DATA, RSP. Reset (rst_i=1 at a clk_i edge) forces IDLE.
- Reset values: req_ready_o=0 during reset; htrans_o=IDLE, hsel_o=0, hwrite_o=0, haddr_o=0, hsize_o=0, hwdata_o=0, hwstrb_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0.
- IDLE:
  - req_ready_o=1; htrans_o=IDLE; hsel_o=0.
  - On accept, capture write, addr, size and wdata.
  - Local reject: any of (size > log2(AhbDataWidth/8)) or (addr & ((1<<size)-1) != 0) -> go to RSP with rsp_error_o=1 and rsp_rdata_o=0. No bus cycle is issued.
  - Otherwise go to ADDR.
- ADDR:
  - Drive hsel_o=1, htrans_o=NONSEQ, haddr_o, hsize_o, hwrite_o from the capture. Hold them stable while hready_i=0.
  - On hready_i=1, go to DATA.
- DATA:
  - htrans_o=IDLE and hsel_o=0. For writes, hwdata_o and hwstrb_o are held from the capture.
  - hwstrb_o = ((1<<(1<<size))-1) << (addr mod (AhbDataWidth/8)) for writes; 0 for reads.
  - Wait while hready_i=0. The first ERROR cycle (hresp_i=1, hready_i=0) is treated as a wait.
  - On hready_i=1, latch rsp_error_o=hresp_i. Latch rsp_rdata_o=hrdata_i for a read without error; otherwise rsp_rdata_o=0. Go to RSP.
- RSP:
  - rsp_valid_o=1; outputs held stable until rsp_ready_i=1, then go to IDLE.
  - req_ready_o=0 here, so a new request can be accepted no earlier than the cycle after the response handshake.
- Latency, zero-wait-state subordinate: accept edge N, address phase cycle N+1, data phase N+2, rsp_valid_o asserted N+3.
- Local reject: rsp_valid_o asserted in the cycle after accept.
- Each wait state adds one cycle. There is no timeout; a subordinate that never asserts hready_i stalls the block indefinitely.
- Only one transfer is ever outstanding. Address and data phases of different transfers never overlap.
- Reset mid-transfer: next state is IDLE with all bus outputs idle. Any pending response is discarded. The subordinate must be reset in the same cycle.
- hburst_o and hprot_o are constant, including during reset.

Test Plan:
- Word read to 0x0000_0010, hready_i always 1, hrdata_i=0xDEADBEEF_01234567 -> NONSEQ one cycle after accept, rsp_valid_o 3 cycles after accept, rsp_rdata_o=0xDEADBEEF_01234567, rsp_error_o=0.
- Byte write of 0xAB to 0x0000_0005, AhbDataWidth=64, req_wdata_i=0x0000_AB00_0000_0000 -> hsize_o=0, hwstrb_o=8'b0010_0000, hwdata_o=0x0000_AB00_0000_0000 in the data phase, rsp_error_o=0.
- Read with 2 address-phase wait states and 3 data-phase wait states -> haddr_o and htrans_o stable during the address waits; rsp_valid_o 8 cycles after accept.
- Write with two-cycle ERROR (hresp_i=1/hready_i=0, then hresp_i=1/hready_i=1) -> rsp_error_o=1, rsp_rdata_o=0, no further NONSEQ issued.
- Misaligned word read at 0x0000_0002, and size=4 request -> no NONSEQ on the bus; rsp_valid_o one cycle after accept with rsp_error_o=1.
- Assert rst_i while in DATA with hready_i=0 -> next cycle IDLE, htrans_o=IDLE, rsp_valid_o=0; hold rsp_ready_i=0 in RSP for 5 cycles -> response stays stable and req_ready_o=0.
